// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two requester FIFOs (ALU, LSU) merged onto one write port.
// Define REGFILE_WB_RR_ARB_EN for round-robin arbitration; fixed priority (port 0) otherwise.

module regfile_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_entry,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_full,
  output logic             not_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Ready depends only on occupancy, so a pop never lets a full FIFO accept.
  assign not_full  = (count != FULL);
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        rf_w_en,
  output logic [5:0]  rf_addr_w,
  output logic [31:0] rf_w_data,
  output logic        idle
);
  logic [36:0] head0, head1, head;
  logic        ne0, ne1;
  logic        push0, push1, pop0, pop1;
  logic        pop_any, grant, last_grant;

  assign push0 = req0_valid & req0_ready;
  assign push1 = req1_valid & req1_ready;

  regfile_wb_fifo #(.DEPTH(DEPTH), .WIDTH(37)) u_fifo0 (
    .clk(clk), .rstn(rstn), .push(push0), .push_entry({req0_addr, req0_data}),
    .pop(pop0), .head(head0), .not_full(req0_ready), .not_empty(ne0)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH), .WIDTH(37)) u_fifo1 (
    .clk(clk), .rstn(rstn), .push(push1), .push_entry({req1_addr, req1_data}),
    .pop(pop1), .head(head1), .not_full(req1_ready), .not_empty(ne1)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    grant   = 1'b0;
    pop_any = ne0 | ne1;
`ifdef REGFILE_WB_RR_ARB_EN
    grant = (ne0 && ne1) ? ~last_grant : ne1;
`else
    grant = ~ne0;
`endif
  end

  assign pop0 = pop_any & ~grant;
  assign pop1 = pop_any & grant;
  assign head = grant ? head1 : head0;

`ifndef REGFILE_WB_RR_ARB_EN
  // Fixed priority tracks last_grant without consuming it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_w_en    <= 1'b0;
      rf_addr_w  <= '0;
      rf_w_data  <= '0;
      last_grant <= 1'b1;
    end else if (pop_any) begin
      // Writes to x0 still retire the entry but never reach the register file.
      rf_w_en    <= (head[36:32] != 5'd0);
      rf_addr_w  <= {1'b0, head[36:32]};
      rf_w_data  <= head[31:0];
      last_grant <= grant;
    end else begin
      rf_w_en <= 1'b0;
    end
  end

  assign idle = ~ne0 & ~ne1 & ~rf_w_en;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue model.
// Honours REGFILE_WB_RR_ARB_EN to pick the expected arbitration policy.

module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        rf_w_en;
  logic [5:0]  rf_addr_w;
  logic [31:0] rf_w_data;
  logic        idle;

  int checks = 0;
  int errors = 0;

  // Reference model state: per-port queues of {addr, data} and the last granted port.
  logic [36:0] q0 [$];
  logic [36:0] q1 [$];
  logic [36:0] wlog [$];
  logic        m_last_grant;
  logic        cur_en;
  logic        last_acc0, last_acc1;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_w_en(rf_w_en), .rf_addr_w(rf_addr_w), .rf_w_data(rf_w_data), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rr_enabled();
`ifdef REGFILE_WB_RR_ARB_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: check pre-edge outputs, advance the model, then check the registered result.
  task automatic cycle();
    logic        acc0, acc1, popped, g;
    logic [36:0] ent;
    check("req0_ready", req0_ready, q0.size() < DEPTH);
    check("req1_ready", req1_ready, q1.size() < DEPTH);
    check("idle", idle, (q0.size() == 0) && (q1.size() == 0) && !cur_en);
    acc0   = req0_valid && (q0.size() < DEPTH);
    acc1   = req1_valid && (q1.size() < DEPTH);
    popped = 1'b1;
    g      = 1'b0;
    if (q0.size() > 0 && q1.size() > 0) g = rr_enabled() ? !m_last_grant : 1'b0;
    else if (q0.size() > 0)             g = 1'b0;
    else if (q1.size() > 0)             g = 1'b1;
    else                                popped = 1'b0;
    ent = '0;
    if (popped) begin
      ent          = g ? q1.pop_front() : q0.pop_front();
      m_last_grant = g;
      cur_en       = (ent[36:32] != 5'd0);
    end else begin
      cur_en = 1'b0;
    end
    if (acc0) q0.push_back({req0_addr, req0_data});
    if (acc1) q1.push_back({req1_addr, req1_data});
    @(posedge clk);
    @(negedge clk);
    check("rf_w_en", rf_w_en, cur_en);
    if (popped) begin
      check("rf_addr_w", rf_addr_w, {1'b0, ent[36:32]});
      check("rf_w_data", rf_w_data, ent[31:0]);
    end
    if (rf_w_en === 1'b1) wlog.push_back({rf_addr_w[4:0], rf_w_data});
    last_acc0 = acc0;
    last_acc1 = acc1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_last_grant = 1'b1;
    cur_en       = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_w_en", rf_w_en, 1'b0);
    check("rst_addr", rf_addr_w, 6'd0);
    check("rst_data", rf_w_data, 32'd0);
    check("rst_idle", idle, 1'b1);
    check("rst_ready0", req0_ready, 1'b1);
    check("rst_ready1", req1_ready, 1'b1);
  endtask

  initial begin
    logic [4:0] exp_order [4];
    logic [36:0] e;
    int k, j, n1;

    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rstn = 1'b1;

    // Single write to x5, accepted at the first edge after reset release.
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check("single_en", rf_w_en, 1'b1);
    check("single_addr", rf_addr_w, 6'd5);
    check("single_data", rf_w_data, 32'hDEAD_BEEF);
    cycle();
    check("single_en_drop", rf_w_en, 1'b0);
    repeat (2) cycle();

    // Contention: two entries per port pushed on the same cycles.
    wlog.delete();
    drive(1, 5'd1, 32'h11, 1, 5'd3, 32'h33);
    cycle();
    drive(1, 5'd2, 32'h22, 1, 5'd4, 32'h44);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) cycle();
    if (rr_enabled()) exp_order = '{5'd1, 5'd3, 5'd2, 5'd4};
    else              exp_order = '{5'd1, 5'd2, 5'd3, 5'd4};
    check("contend_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      check("contend_order", (i < wlog.size()) ? wlog[i][36:32] : 5'h1f, exp_order[i]);

    // Backpressure: req0 saturates while req1 is held valid until accepted.
    wlog.delete();
    k = 0;
    j = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1, 5'd10, 32'h200 + j, 1, 5'(k + 1), 32'h100 + k);
      cycle();
      if (last_acc0) j++;
      if (last_acc1) k++;
      if (c == 1 && !rr_enabled()) check("bp_ready1_low", req1_ready, 1'b0);
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (8) cycle();
    n1 = 0;
    foreach (wlog[i]) begin
      e = wlog[i];
      if (e[31:8] == 24'h1) begin
        check("bp_p1_order", e[7:0], 8'(n1));
        n1++;
      end
    end
    check("bp_p1_count", n1, k);

    // x0 write is popped but never asserts rf_w_en.
    drive(1, 5'd0, 32'h1234_5678, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    check("x0_idle_busy", idle, 1'b0);
    cycle();
    check("x0_w_en", rf_w_en, 1'b0);
    check("x0_idle_back", idle, 1'b1);
    cycle();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
      cycle();
    end

    // Reset asserted mid-cycle with both FIFOs loaded.
    for (int c = 0; c < 4; c++) begin
      drive(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom);
      cycle();
    end
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_reset_state();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wlog.delete();
    repeat (4) cycle();
    check("post_rst_writes", wlog.size(), 0);

    // First push right after release.
    rstn = 1'b0;
    @(negedge clk);
    model_reset();
    rstn = 1'b1;
    drive(1, 5'd7, 32'hCAFE_0007, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check("first_push_en", rf_w_en, 1'b1);
    check("first_push_addr", rf_addr_w, 6'd7);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
